// File: rtl/bc_wb_dist.sv
// Return-direction bus connect: routes one register-file result word per cycle to
// DM, DAG or PS write ports, or into an external-bus FIFO drained by valid/ready.
module bc_wb_dist #(
  parameter int DW       = 16,
  parameter int XB_DEPTH = 4
) (
  input  logic          clk_dcd,
  input  logic          rst,
  input  logic          ps_bc_wr_en,
  input  logic [2:0]    ps_bc_dsel,
  input  logic [DW-1:0] rf_bc_dt,
  output logic [DW-1:0] bc_dm_dt,
  output logic          bc_dm_we,
  output logic [DW-1:0] bc_dg_dt,
  output logic          bc_dg_we,
  output logic [DW-1:0] bc_ps_dt,
  output logic          bc_ps_we,
  output logic [DW-1:0] bc_xb_dt,
  output logic          bc_xb_vld,
  input  logic          xb_bc_rdy,
  output logic          bc_ps_xbfull,
  output logic          bc_ps_ovf
);

  localparam int PW = $clog2(XB_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(XB_DEPTH);

  logic          w_req_dm;
  logic          w_req_dg;
  logic          w_req_ps;
  logic          w_req_xb;
  logic          w_full;
  logic          w_pop;
  logic          w_push;

  logic [DW-1:0] r_mem [XB_DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_cnt;

  assign w_req_dm = ps_bc_wr_en && (ps_bc_dsel == 3'b001);
  assign w_req_dg = ps_bc_wr_en && (ps_bc_dsel == 3'b010);
  assign w_req_ps = ps_bc_wr_en && (ps_bc_dsel == 3'b011);
  assign w_req_xb = ps_bc_wr_en && (ps_bc_dsel == 3'b100);

  assign w_full       = (r_cnt == FULL_CNT);
  assign bc_xb_vld    = (r_cnt != '0);
  assign bc_xb_dt     = r_mem[r_rd];
  assign bc_ps_xbfull = w_full;
  assign w_pop        = bc_xb_vld & xb_bc_rdy;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push       = w_req_xb & (~w_full | w_pop);

  always_ff @(posedge clk_dcd) begin
    if (rst) begin
      bc_dm_dt <= '0;
      bc_dm_we <= 1'b0;
      bc_dg_dt <= '0;
      bc_dg_we <= 1'b0;
      bc_ps_dt <= '0;
      bc_ps_we <= 1'b0;
    end else begin
      bc_dm_we <= w_req_dm;
      bc_dg_we <= w_req_dg;
      bc_ps_we <= w_req_ps;
      if (w_req_dm) bc_dm_dt <= rf_bc_dt;
      if (w_req_dg) bc_dg_dt <= rf_bc_dt;
      if (w_req_ps) bc_ps_dt <= rf_bc_dt;
    end
  end

  // Storage carries no reset; entries are only observable once counted in.
  always_ff @(posedge clk_dcd) begin
    if (!rst && w_push) r_mem[r_wr] <= rf_bc_dt;
  end

  always_ff @(posedge clk_dcd) begin
    if (rst) begin
      r_rd      <= '0;
      r_wr      <= '0;
      r_cnt     <= '0;
      bc_ps_ovf <= 1'b0;
    end else begin
      if (w_pop)  r_rd <= r_rd + PW'(1);
      if (w_push) r_wr <= r_wr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_req_xb && !w_push) bc_ps_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bc_wb_dist.sv
// Directed bench for bc_wb_dist: a queue-based reference model checked every cycle,
// plus literal expectations at the points the test plan calls out.
module tb_bc_wb_dist;

  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wrEn = 1'b0;
  logic [2:0]    dsel = 3'b000;
  logic [DW-1:0] data = '0;
  logic          xbRdy = 1'b0;

  logic [DW-1:0] dmDt, dgDt, psDt, xbDt;
  logic          dmWe, dgWe, psWe, xbVld, xbFull, ovf;

  int tests = 0;
  int fails = 0;
  bit checkEn = 1'b0;

  // reference model state
  logic [DW-1:0] mDm = '0, mDg = '0, mPs = '0;
  logic          mDmWe = 0, mDgWe = 0, mPsWe = 0, mOvf = 0;
  logic [DW-1:0] mQ[$];
  logic [DW-1:0] recvQ[$];

  bc_wb_dist #(.DW(DW), .XB_DEPTH(DEPTH)) dut (
    .clk_dcd(clk), .rst(rst),
    .ps_bc_wr_en(wrEn), .ps_bc_dsel(dsel), .rf_bc_dt(data),
    .bc_dm_dt(dmDt), .bc_dm_we(dmWe),
    .bc_dg_dt(dgDt), .bc_dg_we(dgWe),
    .bc_ps_dt(psDt), .bc_ps_we(psWe),
    .bc_xb_dt(xbDt), .bc_xb_vld(xbVld), .xb_bc_rdy(xbRdy),
    .bc_ps_xbfull(xbFull), .bc_ps_ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [2:0] sel, input logic [DW-1:0] d, input logic rdy);
    wrEn = wr; dsel = sel; data = d; xbRdy = rdy;
    @(posedge clk);
    #1;
  endtask

  // Model: each destination register is "last word sent there"; the FIFO is a plain queue.
  always @(posedge clk) begin
    logic popNow;
    if (rst) begin
      mDm = '0; mDg = '0; mPs = '0;
      mDmWe = 0; mDgWe = 0; mPsWe = 0; mOvf = 0;
      mQ.delete();
    end else begin
      mDmWe = wrEn && dsel == 3'd1;
      mDgWe = wrEn && dsel == 3'd2;
      mPsWe = wrEn && dsel == 3'd3;
      if (mDmWe) mDm = data;
      if (mDgWe) mDg = data;
      if (mPsWe) mPs = data;
      popNow = (mQ.size() != 0) && xbRdy;
      if (popNow) void'(mQ.pop_front());
      if (wrEn && dsel == 3'd4) begin
        if (mQ.size() < DEPTH) mQ.push_back(data);
        else mOvf = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, plus a log of words the bus accepted.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("dm_dt", dmDt, mDm);
      checkOutput("dm_we", {15'b0, dmWe}, {15'b0, mDmWe});
      checkOutput("dg_dt", dgDt, mDg);
      checkOutput("dg_we", {15'b0, dgWe}, {15'b0, mDgWe});
      checkOutput("ps_dt", psDt, mPs);
      checkOutput("ps_we", {15'b0, psWe}, {15'b0, mPsWe});
      checkOutput("xb_vld", {15'b0, xbVld}, {15'b0, (mQ.size() != 0)});
      checkOutput("xbfull", {15'b0, xbFull}, {15'b0, (mQ.size() == DEPTH)});
      checkOutput("ovf", {15'b0, ovf}, {15'b0, mOvf});
      if (mQ.size() != 0) checkOutput("xb_dt", xbDt, mQ[0]);
      if (xbVld === 1'b1 && xbRdy) recvQ.push_back(xbDt);
    end
  end

  initial begin
    int base;
    applyStimulus(0, 3'd0, '0, 0);
    applyStimulus(0, 3'd0, '0, 0);
    rst = 1'b0;
    checkEn = 1'b1;
    checkOutput("rst_dm_we", {15'b0, dmWe}, 16'h0);
    checkOutput("rst_vld", {15'b0, xbVld}, 16'h0);
    checkOutput("rst_ovf", {15'b0, ovf}, 16'h0);

    // path latency
    applyStimulus(1, 3'd1, 16'h1234, 0);
    checkOutput("lat_dm_we", {15'b0, dmWe}, 16'h1);
    checkOutput("lat_dm_dt", dmDt, 16'h1234);
    applyStimulus(1, 3'd2, 16'hBEEF, 0);
    checkOutput("lat_dm_we_off", {15'b0, dmWe}, 16'h0);
    checkOutput("lat_dg_dt", dgDt, 16'hBEEF);
    checkOutput("lat_dm_hold", dmDt, 16'h1234);
    applyStimulus(1, 3'd3, 16'h0F0F, 0);
    checkOutput("lat_ps_we", {15'b0, psWe}, 16'h1);
    checkOutput("lat_ps_dt", psDt, 16'h0F0F);
    applyStimulus(0, 3'd0, '0, 0);
    checkOutput("lat_ps_we_off", {15'b0, psWe}, 16'h0);

    // back-to-back DM, then an invalid destination
    applyStimulus(1, 3'd1, 16'h0001, 0);
    checkOutput("b2b_dt0", dmDt, 16'h0001);
    applyStimulus(1, 3'd1, 16'h0002, 0);
    checkOutput("b2b_we1", {15'b0, dmWe}, 16'h1);
    checkOutput("b2b_dt1", dmDt, 16'h0002);
    applyStimulus(1, 3'd5, 16'hFFFF, 0);
    checkOutput("bad_sel_we", {13'b0, dmWe, dgWe, psWe}, 16'h0);
    checkOutput("bad_sel_dt", dmDt, 16'h0002);

    // fill and overflow
    for (int i = 0; i < 4; i++) applyStimulus(1, 3'd4, 16'h0010 + 16'(i), 0);
    checkOutput("fill_full", {15'b0, xbFull}, 16'h1);
    checkOutput("fill_head", xbDt, 16'h0010);
    applyStimulus(1, 3'd4, 16'h0014, 0);
    checkOutput("ovf_set", {15'b0, ovf}, 16'h1);
    checkOutput("ovf_full", {15'b0, xbFull}, 16'h1);
    base = recvQ.size();
    for (int i = 0; i < 4; i++) applyStimulus(0, 3'd0, '0, 1);
    checkOutput("drain_vld", {15'b0, xbVld}, 16'h0);
    checkOutput("drain_ovf", {15'b0, ovf}, 16'h1);
    checkOutput("drain_cnt", 16'(recvQ.size() - base), 16'd4);
    for (int i = 0; i < 4; i++)
      if (base + i < recvQ.size()) checkOutput("drain_word", recvQ[base + i], 16'h0010 + 16'(i));

    // reset mid-stream with three entries queued
    for (int i = 0; i < 3; i++) applyStimulus(1, 3'd4, 16'h0030 + 16'(i), 0);
    applyStimulus(1, 3'd1, 16'h5555, 0);
    rst = 1'b1;
    applyStimulus(0, 3'd0, '0, 0);
    applyStimulus(0, 3'd0, '0, 0);
    rst = 1'b0;
    checkOutput("rst2_dt", dmDt | dgDt | psDt, 16'h0);
    checkOutput("rst2_flags", {11'b0, dmWe, dgWe, psWe, xbVld, xbFull}, 16'h0);
    checkOutput("rst2_ovf", {15'b0, ovf}, 16'h0);
    applyStimulus(1, 3'd4, 16'h00A5, 0);
    checkOutput("rst2_vld", {15'b0, xbVld}, 16'h1);
    checkOutput("rst2_head", xbDt, 16'h00A5);
    applyStimulus(0, 3'd0, '0, 1);

    // full with simultaneous push and pop
    for (int i = 0; i < 4; i++) applyStimulus(1, 3'd4, 16'h0010 + 16'(i), 0);
    base = recvQ.size();
    applyStimulus(1, 3'd4, 16'h0020, 1);
    checkOutput("pp_ovf", {15'b0, ovf}, 16'h0);
    checkOutput("pp_full", {15'b0, xbFull}, 16'h1);
    checkOutput("pp_head", xbDt, 16'h0011);
    for (int i = 0; i < 4; i++) applyStimulus(0, 3'd0, '0, 1);
    checkOutput("pp_cnt", 16'(recvQ.size() - base), 16'd5);
    if (recvQ.size() >= base + 5) begin
      checkOutput("pp_w0", recvQ[base], 16'h0010);
      checkOutput("pp_w1", recvQ[base + 1], 16'h0011);
      checkOutput("pp_w4", recvQ[base + 4], 16'h0020);
    end

    // wrap-around stream with ready toggling every cycle
    base = recvQ.size();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 3'd4, 16'h0100 + 16'(i), 1);
      applyStimulus(0, 3'd0, '0, 0);
    end
    for (int i = 0; i < 3; i++) applyStimulus(0, 3'd0, '0, 1);
    checkOutput("wrap_cnt", 16'(recvQ.size() - base), 16'd10);
    for (int i = 0; i < 10; i++)
      if (base + i < recvQ.size()) checkOutput("wrap_word", recvQ[base + i], 16'h0100 + 16'(i));
    checkOutput("wrap_ovf", {15'b0, ovf}, 16'h0);
    checkOutput("wrap_vld", {15'b0, xbVld}, 16'h0);

    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bc_wb_dist.md
Name: bc_wb_dist

Overview:
- Return-direction bus-connect block. It takes one 16-bit result word per cycle from the register file and distributes it to a destination: data memory, DAG register, program-sequencer register, or external bus.
- The DM, DAG and PS paths are single-cycle registered write ports.
- The external-bus path is buffered in a FIFO and drained with a valid/ready handshake. The sequencer sees full and overflow status.

Parameters:
DW, 16, data width of all data ports
XB_DEPTH, 4, external-bus FIFO entries (power of two, ≥2)

Ports:
clk_dcd  in  1  core clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
ps_bc_wr_en  in  1  sequencer: transfer request this cycle
ps_bc_dsel  in  3  destination: 000 none, 001 DM, 010 DAG, 011 PS, 100 XB, others none
rf_bc_dt  in  DW  source data from register file
bc_dm_dt  out  DW  write data to data memory
bc_dm_we  out  1  one-cycle write strobe to data memory
bc_dg_dt  out  DW  write data to DAG registers
bc_dg_we  out  1  one-cycle write strobe to DAG
bc_ps_dt  out  DW  write data to sequencer registers
bc_ps_we  out  1  one-cycle write strobe to sequencer
bc_xb_dt  out  DW  external-bus data (FIFO head)
bc_xb_vld  out  1  FIFO head valid
xb_bc_rdy  in  1  external bus accepts head this cycle
bc_ps_xbfull  out  1  FIFO count == XB_DEPTH
bc_ps_ovf  out  1  sticky: an XB write was dropped

Behaviour:
- Reset (rst=1 at posedge) drives these to zero:
  - all *_dt outputs
  - all *_we strobes
  - bc_xb_vld, bc_ps_xbfull, bc_ps_ovf
  - FIFO read pointer, write pointer and count
- Reset overrides any in-flight request or pop. FIFO contents are discarded; storage array need not be cleared.
- A request is valid when ps_bc_wr_en=1 and ps_bc_dsel is one of 001–100. Requests with any other dsel, or with wr_en=0, cause no state change other than the strobe clears below.
- DM/DAG/PS paths:
  - Request sampled at edge N.
  - At edge N the selected *_dt register loads rf_bc_dt and the matching *_we goes to 1. Output is visible during cycle N+1 (latency 1).
  - *_we is 1 for exactly one cycle. It returns to 0 at the next edge unless a new request targets the same destination, in which case it stays 1 for back-to-back transfers.
  - A *_dt register holds its last value when not written. Only the selected destination's data and strobe change.
- XB FIFO:
  - Circular buffer with ptr width log2(XB_DEPTH) and count width log2(XB_DEPTH)+1.
  - push = XB request. pop = bc_xb_vld & xb_bc_rdy.
  - bc_xb_vld = (count != 0). bc_xb_dt = entry at the read pointer.
  - bc_xb_vld and bc_xb_dt are combinational from registered state.
  - Push into an empty FIFO at edge N: vld=1 and data valid in cycle N+1. There is no bypass of the same-cycle input.
  - Pop: read pointer advances mod XB_DEPTH. Push: write pointer advances mod XB_DEPTH. Pointers wrap silently.
  - Simultaneous push and pop with count < XB_DEPTH: both occur, count unchanged.
  - Push when count == XB_DEPTH and no pop that cycle: push dropped, pointers and count unchanged, bc_ps_ovf set to 1.
  - Push when count == XB_DEPTH with a pop the same cycle: push accepted, count stays XB_DEPTH, no overflow.
  - Pop when empty: impossible, since vld=0.
  - bc_ps_ovf stays 1 until rst.
  - bc_ps_xbfull = (count == XB_DEPTH), combinational from registered count.
  - Once vld=1, the head data is stable until popped or reset. The external bus may hold rdy=1 continuously.
- Requests to DM/DAG/PS are never stalled and do not interact with FIFO state.

Test Plan:
- Reset: assert rst for 2 cycles mid-stream with the FIFO holding 3 entries -> the cycle after, all outputs are 0 and count is 0. The next XB push of 0x00A5 appears on bc_xb_dt the following cycle with vld=1.
- Path latency: DM request 0x1234 at edge 1, DAG 0xBEEF at edge 2, PS 0x0F0F at edge 3 ->
  - bc_dm_we=1 only in cycle 2 with bc_dm_dt=0x1234; dm_dt holds 0x1234 afterwards.
  - DAG strobe and data in cycle 3; PS strobe and data in cycle 4.
- Back-to-back: DM requests 0x0001 and 0x0002 on consecutive edges -> bc_dm_we stays high for 2 cycles with data 0x0001 then 0x0002. dsel=101 with wr_en=1 -> no strobes.
- FIFO fill/overflow: rdy=0, push 0x0010,0x0011,0x0012,0x0013 -> xbfull=1. Push 0x0014 -> dropped, ovf=1, count 4. Then rdy=1 -> bus receives 0x0010..0x0013 in order over 4 cycles, then vld=0; ovf stays 1.
- Full push+pop: FIFO full with rdy=1 and a simultaneous push of 0x0020 -> head 0x0010 popped, 0x0020 accepted, ovf stays 0, xbfull stays 1. Draining yields 0x0011,0x0012,0x0013,0x0020.
- Wrap-around: stream 10 XB pushes (0x0100..0x0109) with rdy toggling 1,0,1,0 -> all 10 words delivered exactly once, in order, no ovf, pointers wrap past XB_DEPTH.
